wb_write_sched: RTL

Writeback port scheduler for the dual-issue pipeline. Accepts up to two register writes per cycle from WB lanes 1 and 2 and drains them in program order through the single register-file write port. Buffering is a small in-order FIFO; the block back-pressures the pipeline with a stall when the FIFO cannot absorb another dual write. It sits between wb_stage outputs and the register file.

---
 rtl/wb_write_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_write_sched.sv
// wb_write_sched
//   Writeback port scheduler for the dual-issue pipeline. Up to two register
//   writes per cycle arrive from WB lanes 1 (older) and 2 (younger). They are
//   buffered in a small in-order FIFO and drained one per cycle through the
//   single register-file write port. A stall is raised when the FIFO could
//   not absorb another dual write.
//
//   Optional feature macro: WB_FWD_EN
//     Defined   -> adds the forwarding query ports i_RA1/i_RA2 and
//                  o_fwd_hit1/2, o_fwd_data1/2, which search the FIFO
//                  contents for the youngest pending write to each address.
//     Undefined -> those ports and their compare logic are not built.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   i_RegWrite1W/i_WA1W/i_Result1W  lane 1 write request, address, data
//   i_RegWrite2W/i_WA2W/i_Result2W  lane 2 write request, address, data
//   o_stall                      upstream must hold WB inputs this cycle
//   o_we/o_wa/o_wd               register-file write port (FIFO head)
//   o_count                      FIFO occupancy
//   i_RA1/i_RA2                  forwarding query addresses (WB_FWD_EN)
//   o_fwd_hit1/2, o_fwd_data1/2  forwarding results (WB_FWD_EN)

`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module wb_write_sched #(
  parameter int DW    = `D_WIDTH,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_RegWrite1W,
  input  logic [AW-1:0]           i_WA1W,
  input  logic [DW-1:0]           i_Result1W,
  input  logic                    i_RegWrite2W,
  input  logic [AW-1:0]           i_WA2W,
  input  logic [DW-1:0]           i_Result2W,
  output logic                    o_stall,
  output logic                    o_we,
  output logic [AW-1:0]           o_wa,
  output logic [DW-1:0]           o_wd,
  output logic [$clog2(DEPTH):0]  o_count
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0]           i_RA1,
  input  logic [AW-1:0]           i_RA2,
  output logic                    o_fwd_hit1,
  output logic                    o_fwd_hit2,
  output logic [DW-1:0]           o_fwd_data1,
  output logic [DW-1:0]           o_fwd_data2
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Stall once fewer than two free slots remain.
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 2);

  // ---- stage p0: FIFO state ----
  logic [PW-1:0] rd_ptr_p0;
  logic [PW-1:0] wr_ptr_p0;
  logic [CW-1:0] count_p0;
  logic [AW-1:0] fifo_wa_p0 [DEPTH];
  logic [DW-1:0] fifo_wd_p0 [DEPTH];

  logic          stall;
  logic          squash1;
  logic          push1;
  logic          push2;
  logic          pop;
  logic [PW-1:0] wr_ptr2;
  logic [CW-1:0] n_push;

  assign stall = count_p0 > STALL_LVL;

  // Same destination on both lanes: only the younger result matters, so the
  // older one never occupies a slot.
  assign squash1 = i_RegWrite1W && i_RegWrite2W && (i_WA1W == i_WA2W);
  assign push1   = !stall && i_RegWrite1W && !squash1;
  assign push2   = !stall && i_RegWrite2W;
  assign pop     = count_p0 != '0;

  // Lane 2 lands directly behind lane 1 when both are pushed.
  assign wr_ptr2 = wr_ptr_p0 + PW'(push1);
  assign n_push  = CW'(push1) + CW'(push2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      rd_ptr_p0 <= rd_ptr_p0 + PW'(pop);
      wr_ptr_p0 <= wr_ptr_p0 + PW'(push1) + PW'(push2);
      count_p0  <= count_p0 + n_push - CW'(pop);
    end
  end

  // Slot contents are only meaningful under count, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push1) begin
      fifo_wa_p0[wr_ptr_p0] <= i_WA1W;
      fifo_wd_p0[wr_ptr_p0] <= i_Result1W;
    end
    if (push2) begin
      fifo_wa_p0[wr_ptr2] <= i_WA2W;
      fifo_wd_p0[wr_ptr2] <= i_Result2W;
    end
  end

  // ---- register-file port: head of FIFO ----
  assign o_stall = stall;
  assign o_count = count_p0;
  assign o_we    = pop;
  assign o_wa    = pop ? fifo_wa_p0[rd_ptr_p0] : '0;
  assign o_wd    = pop ? fifo_wd_p0[rd_ptr_p0] : '0;

`ifdef WB_FWD_EN
  // Walk entries from oldest to youngest so the last match seen is the
  // youngest one. Returns {hit, data}.
  function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] ra);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_p0 + PW'(k);
      if ((CW'(k) < count_p0) && (fifo_wa_p0[idx] == ra)) begin
        res = {1'b1, fifo_wd_p0[idx]};
      end
    end
    return res;
  endfunction

  logic [DW:0] fwd1;
  logic [DW:0] fwd2;

  always_comb begin
    fwd1 = fwd_lookup(i_RA1);
    fwd2 = fwd_lookup(i_RA2);
  end

  assign o_fwd_hit1  = fwd1[DW];
  assign o_fwd_data1 = fwd1[DW-1:0];
  assign o_fwd_hit2  = fwd2[DW];
  assign o_fwd_data2 = fwd2[DW-1:0];
`endif

endmodule
